// File: rtl/ring_out_arb.sv
// Ring-stop output arbiter: pops one flit per cycle from the ring-through or local FIFO
// into a single output register, with ring priority bounded by a starvation counter.
module ring_out_arb #(
    parameter int WIDTH      = 8,
    parameter int STARVE_MAX = 4     // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iRingEmpty,
    input  logic [WIDTH-1:0] iRingDat,
    output logic             oRingRdEn,
    input  logic             iLocEmpty,
    input  logic [WIDTH-1:0] iLocDat,
    output logic             oLocRdEn,
    output logic             oVld,
    output logic [WIDTH-1:0] oDat,
    input  logic             iRdy,
    output logic             oStarve
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] dat_reg, dat_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0] sel_dat;
    logic             can_load;
    logic             sel_ring;
    logic             sel_loc;

    assign can_load = (state_reg == S_EMPTY) || iRdy;
    // Ring wins unless local has waited through CNT_MAX ring grants.
    assign sel_ring = !iRingEmpty && (iLocEmpty || (cnt_reg < CNT_MAX));
    assign sel_loc  = !iLocEmpty && !sel_ring;

    assign oRingRdEn = can_load && sel_ring && !rst;
    assign oLocRdEn  = can_load && sel_loc  && !rst;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign sel_dat[gi] = sel_ring ? iRingDat[gi] : iLocDat[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        dat_next   = dat_reg;
        cnt_next   = cnt_reg;

        if (oRingRdEn || oLocRdEn) begin
            state_next = S_FULL;
            dat_next   = sel_dat;
        end else if (can_load) begin
            state_next = S_EMPTY;
        end

        // Counter only tracks ring grants made while a local flit is actually waiting.
        if (oLocRdEn || iLocEmpty) begin
            cnt_next = 4'd0;
        end else if (oRingRdEn) begin
            cnt_next = (cnt_reg >= CNT_MAX) ? CNT_MAX : cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_EMPTY;
            dat_reg   <= '0;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            dat_reg   <= dat_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign oVld    = (state_reg == S_FULL);
    assign oDat    = dat_reg;
    assign oStarve = (cnt_reg == CNT_MAX);

endmodule

// File: tb/tb_ring_out_arb.sv
// Directed bench for ring_out_arb: queue-based FIFO models feed the arbiter, expected
// flits go into a scoreboard queue that a negedge monitor drains on each accept.
module tb_ring_out_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iRingEmpty, iLocEmpty, iRdy;
    logic [7:0] iRingDat, iLocDat;
    logic       oRingRdEn, oLocRdEn, oVld, oStarve;
    logic [7:0] oDat;

    logic [7:0] ring_q[$];
    logic [7:0] loc_q[$];
    logic [7:0] exp_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic pend_ring = 1'b0, pend_loc = 1'b0;
    logic prev_vld = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b1;
    logic [7:0] prev_dat = 8'h00;

    ring_out_arb #(.WIDTH(8), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .iRingEmpty(iRingEmpty), .iRingDat(iRingDat), .oRingRdEn(oRingRdEn),
        .iLocEmpty(iLocEmpty), .iLocDat(iLocDat), .oLocRdEn(oLocRdEn),
        .oVld(oVld), .oDat(oDat), .iRdy(iRdy), .oStarve(oStarve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd();
        iRingEmpty = (ring_q.size() == 0);
        iRingDat   = iRingEmpty ? 8'h00 : ring_q[0];
        iLocEmpty  = (loc_q.size() == 0);
        iLocDat    = iLocEmpty ? 8'h00 : loc_q[0];
    endtask

    // Advance one clock; FIFO pops seen at the previous negedge take effect after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (pend_ring && ring_q.size() != 0) void'(ring_q.pop_front());
        if (pend_loc && loc_q.size() != 0) void'(loc_q.pop_front());
        upd();
    endtask

    // Monitor: protocol checks every cycle, scoreboard compare on every accepted flit.
    always @(negedge clk) begin
        logic [7:0] e;
        chk("excl_strobes", {31'd0, oRingRdEn && oLocRdEn}, 0);
        chk("ring_pop_empty", {31'd0, oRingRdEn && iRingEmpty}, 0);
        chk("loc_pop_empty", {31'd0, oLocRdEn && iLocEmpty}, 0);
        if (rst) chk("rst_no_pop", {31'd0, oRingRdEn || oLocRdEn}, 0);
        if (oVld && !iRdy) chk("hold_no_pop", {31'd0, oRingRdEn || oLocRdEn}, 0);
        if (prev_vld && !prev_rdy && !prev_rst) begin
            chk("hold_vld", {31'd0, oVld}, 1);
            chk("hold_dat", {24'd0, oDat}, {24'd0, prev_dat});
        end
        if (!rst && oVld && iRdy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h, expected no flit at %0t", oDat, $time);
            end else begin
                e = exp_q.pop_front();
                $display("accept flit 0x%02h (expected 0x%02h) at %0t", oDat, e, $time);
                chk("sb_dat", {24'd0, oDat}, {24'd0, e});
            end
        end
        pend_ring <= oRingRdEn;
        pend_loc  <= oLocRdEn;
        prev_vld  <= oVld;
        prev_rdy  <= iRdy;
        prev_rst  <= rst;
        prev_dat  <= oDat;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRdy = 1'b1;
        upd();

        // Reset with both FIFOs non-empty
        ring_q.push_back(8'h51);
        loc_q.push_back(8'h52);
        upd();
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("rst_vld", {31'd0, oVld}, 0);
            chk("rst_dat", {24'd0, oDat}, 0);
            chk("rst_ring_rden", {31'd0, oRingRdEn}, 0);
        end
        step();
        rst = 1'b0;
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h52);
        @(negedge clk);
        chk("first_pop_after_rst", {31'd0, oRingRdEn}, 1);
        step();
        @(negedge clk);
        chk("rst_flit1_dat", {24'd0, oDat}, 32'h51);
        chk("rst_loc_rden", {31'd0, oLocRdEn}, 1);
        step();
        @(negedge clk);
        chk("rst_flit2_dat", {24'd0, oDat}, 32'h52);
        step();
        @(negedge clk);
        chk("rst_idle_vld", {31'd0, oVld}, 0);
        step();

        // Ring-only stream
        for (int v = 1; v <= 5; v++) begin
            ring_q.push_back(8'(v));
            exp_q.push_back(8'(v));
        end
        upd();
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk("stream_ring_rden", {31'd0, oRingRdEn}, {31'd0, k < 5});
            chk("stream_loc_rden", {31'd0, oLocRdEn}, 0);
            chk("stream_vld", {31'd0, oVld}, {31'd0, k >= 1 && k <= 5});
            if (k >= 1 && k <= 5) chk("stream_dat", {24'd0, oDat}, k);
            step();
        end

        // Starvation release
        for (int v = 0; v < 8; v++) begin
            ring_q.push_back(8'h10 + 8'(v));
        end
        loc_q.push_back(8'hA0);
        foreach (ring_q[i]) if (i < 4) exp_q.push_back(ring_q[i]);
        exp_q.push_back(8'hA0);
        for (int v = 4; v < 8; v++) exp_q.push_back(8'h10 + 8'(v));
        upd();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk("starve_flag", {31'd0, oStarve}, {31'd0, k == 4});
            chk("starve_loc_rden", {31'd0, oLocRdEn}, {31'd0, k == 4});
            chk("starve_ring_rden", {31'd0, oRingRdEn}, {31'd0, k <= 8 && k != 4});
            chk("starve_vld", {31'd0, oVld}, {31'd0, k >= 1 && k <= 9});
            step();
        end

        // Backpressure hold, counter must survive the hold
        for (int v = 1; v <= 5; v++) ring_q.push_back(8'h10 + 8'(v));
        loc_q.push_back(8'hB0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h13);
        exp_q.push_back(8'h14);
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'h15);
        upd();
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 0 || k == 7 || k == 9 || k == 11) chk("bp_ring_rden", {31'd0, oRingRdEn}, 1);
            if (k >= 1 && k <= 6) begin
                chk("bp_hold_dat", {24'd0, oDat}, 32'h11);
                chk("bp_hold_starve", {31'd0, oStarve}, 0);
            end
            if (k == 8) begin
                chk("bp_no_bubble_vld", {31'd0, oVld}, 1);
                chk("bp_no_bubble_dat", {24'd0, oDat}, 32'h12);
            end
            if (k == 10) begin
                chk("bp_starve", {31'd0, oStarve}, 1);
                chk("bp_loc_rden", {31'd0, oLocRdEn}, 1);
            end
            if (k == 13) chk("bp_idle_vld", {31'd0, oVld}, 0);
            step();
            if (k == 0) iRdy = 1'b0;
            if (k == 6) iRdy = 1'b1;
        end

        // Drain to idle
        ring_q.push_back(8'h33);
        exp_q.push_back(8'h33);
        upd();
        @(negedge clk);
        chk("drain_ring_rden", {31'd0, oRingRdEn}, 1);
        step();
        @(negedge clk);
        chk("drain_vld", {31'd0, oVld}, 1);
        chk("drain_dat", {24'd0, oDat}, 32'h33);
        step();
        @(negedge clk);
        chk("drain_idle_vld", {31'd0, oVld}, 0);
        chk("drain_keep_dat", {24'd0, oDat}, 32'h33);
        chk("drain_idle_rden", {31'd0, oRingRdEn || oLocRdEn}, 0);
        step();

        // Reset while holding a flit
        for (int v = 4; v <= 9; v++) ring_q.push_back(8'h40 + 8'(v));
        loc_q.push_back(8'hC0);
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h46);
        exp_q.push_back(8'h47);
        exp_q.push_back(8'h48);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h49);
        upd();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) chk("mid_hold_dat", {24'd0, oDat}, 32'h44);
            if (k == 3) begin
                chk("mid_rst_vld", {31'd0, oVld}, 0);
                chk("mid_rst_dat", {24'd0, oDat}, 0);
                chk("mid_rst_starve", {31'd0, oStarve}, 0);
            end
            if (k == 0 || (k >= 3 && k <= 6) || k == 8) chk("mid_ring_rden", {31'd0, oRingRdEn}, 1);
            if (k == 7) begin
                chk("mid_starve", {31'd0, oStarve}, 1);
                chk("mid_loc_rden", {31'd0, oLocRdEn}, 1);
            end
            if (k == 10) chk("mid_idle_vld", {31'd0, oVld}, 0);
            step();
            if (k == 0) iRdy = 1'b0;
            if (k == 1) rst = 1'b1;
            if (k == 2) begin
                rst  = 1'b0;
                iRdy = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        chk("sb_all_consumed", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
